// File: rtl/data_mem_block_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_block_reader_pkg
// Description : Shared constants and FSM state type for the data-memory
//               block reader and the memory wrapper it sits in front of.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_block_reader_pkg;

    localparam int MEM_DATA_W = 32;
    localparam int MEM_ADDR_W = 9;
    localparam int MEM_DEPTH  = 342;
    localparam int MEM_LEN_W  = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/data_mem_block_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_block_reader_if
// Description : Avalon-MM read port toward the data memory plus the
//               valid/ready output stream of the block reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_block_reader_if
    import data_mem_block_reader_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W
) ();

    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_clken;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;

    modport master (
        output mem_address, mem_chipselect, mem_clken, mem_write,
        output mem_byteenable, mem_writedata,
        input  mem_readdata,
        output out_data, out_valid, out_last,
        input  out_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_clken, mem_write,
        input  mem_byteenable, mem_writedata,
        output mem_readdata,
        input  out_data, out_valid, out_last,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/data_mem_rd_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_rd_skid_fifo
// Description : 2-entry valid/ready buffer; an incoming word falls straight
//               through to the head when the buffer is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_rd_skid_fifo #(
    parameter int DATA_W = 32
) (
    input  wire               clk,
    input  wire               rst_n,
    input  wire               in_valid,
    input  wire  [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  wire               out_ready,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] entry_q [2];
    logic [DATA_W-1:0] entry_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              wr_ptr;
    logic              store;
    logic              pop_buf;

    always_comb begin
        entry_d   = entry_q;
        out_valid = (count_q != 2'd0) || in_valid;
        out_data  = (count_q != 2'd0) ? entry_q[rd_ptr_q] : in_data;
        // Tail slot; with two words stored this is the head slot being freed.
        wr_ptr    = rd_ptr_q ^ count_q[0];
        store     = in_valid && ((count_q != 2'd0) || !out_ready);
        pop_buf   = out_ready && (count_q != 2'd0);
        if (store) begin
            entry_d[wr_ptr] = in_data;
        end
        rd_ptr_d  = rd_ptr_q ^ pop_buf;
        count_d   = count_q + {1'b0, store} - {1'b0, pop_buf};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            entry_q    <= entry_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_block_reader.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_block_reader
// Description : Streams a contiguous block of the on-chip data memory out on a
//               valid/ready interface, keeping at most two words ahead of the sink.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_block_reader
    import data_mem_block_reader_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DEPTH  = MEM_DEPTH,
    parameter int LEN_W  = MEM_LEN_W
) (
    input  wire               clk,
    input  wire               reset_n,
    input  wire               start,
    input  wire  [ADDR_W-1:0] base_addr,
    input  wire  [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              error,
    data_mem_block_reader_if.master bus
);

    localparam int               EXT_W     = LEN_W + 1 - ADDR_W;
    localparam logic [LEN_W:0]   DEPTH_EXT = (LEN_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  issue_rem_q, issue_rem_d;
    logic [LEN_W-1:0]  recv_rem_q, recv_rem_d;
    logic              inflight_q, inflight_d;
    logic              zero_done_q, zero_done_d;
    logic              error_q, error_d;

    logic [1:0]        fifo_count;
    logic              fifo_valid;
    logic [DATA_W-1:0] fifo_data;
    logic [1:0]        occupancy;
    logic [LEN_W:0]    end_addr;
    logic              start_ok;
    logic              xfer;
    logic              issue;
    logic              last_xfer;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_rem_d = issue_rem_q;
        recv_rem_d  = recv_rem_q;
        error_d     = 1'b0;
        zero_done_d = 1'b0;

        end_addr  = {{EXT_W{1'b0}}, base_addr} + {1'b0, length};
        start_ok  = start && (state_q == ST_IDLE) && !zero_done_q;
        xfer      = fifo_valid && bus.out_ready;
        last_xfer = (state_q != ST_IDLE) && xfer && (recv_rem_q == LEN_W'(1));
        occupancy = fifo_count + {1'b0, inflight_q};
        // A full pipeline may still issue when the sink frees a slot this cycle.
        issue     = (state_q == ST_RUN) && (issue_rem_q != '0) &&
                    ((occupancy < 2'd2) || ((occupancy == 2'd2) && xfer));
        inflight_d = issue;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    if (end_addr > DEPTH_EXT) begin
                        error_d = 1'b1;
                    end else if (length == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        state_d     = ST_RUN;
                        addr_d      = base_addr;
                        issue_rem_d = length;
                        recv_rem_d  = length;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    issue_rem_d = issue_rem_q - LEN_W'(1);
                    // Address is held on the final word so it never passes DEPTH-1.
                    if (issue_rem_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q != ST_IDLE) && xfer) begin
            recv_rem_d = recv_rem_q - LEN_W'(1);
            if (recv_rem_q == LEN_W'(1)) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            issue_rem_q <= '0;
            recv_rem_q  <= '0;
            inflight_q  <= 1'b0;
            zero_done_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_rem_q <= issue_rem_d;
            recv_rem_q  <= recv_rem_d;
            inflight_q  <= inflight_d;
            zero_done_q <= zero_done_d;
            error_q     <= error_d;
        end
    end

    data_mem_rd_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .in_valid  (inflight_q),
        .in_data   (bus.mem_readdata),
        .out_valid (fifo_valid),
        .out_data  (fifo_data),
        .out_ready (bus.out_ready),
        .count     (fifo_count)
    );

    assign bus.mem_address    = addr_q;
    assign bus.mem_chipselect = issue;
    assign bus.mem_clken      = 1'b1;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 4'hF;
    assign bus.mem_writedata  = '0;

    assign bus.out_data  = fifo_data;
    assign bus.out_valid = fifo_valid;
    assign bus.out_last  = fifo_valid && (recv_rem_q == LEN_W'(1));

    assign busy  = (state_q != ST_IDLE) || zero_done_q;
    assign done  = last_xfer || zero_done_q;
    assign error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_block_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_block_reader
// Description : Self-checking bench: block table, random blocks, reset corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_block_reader;
    import data_mem_block_reader_pkg::*;

    localparam int DATA_W = MEM_DATA_W;
    localparam int ADDR_W = MEM_ADDR_W;
    localparam int DEPTH  = MEM_DEPTH;
    localparam int LEN_W  = MEM_LEN_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;
    logic              error;
    logic              ready;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] mem_model [DEPTH];

    int total = 0;
    int bad   = 0;

    data_mem_block_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    data_mem_block_reader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .LEN_W  (LEN_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Single-port memory with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.mem_chipselect) begin
            if (int'(bus.mem_address) < DEPTH) rd_q <= mem_model[bus.mem_address];
            else                               rd_q <= 32'hDEAD_BEEF;
        end
    end

    assign bus.mem_readdata = rd_q;
    assign bus.out_ready    = ready;

    function automatic void check(string name, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic ready_fn(int mode, int k);
        logic [5:0] pat;
        pat = 6'b101001;
        case (mode)
            0:       return 1'b1;
            1:       return pat[k % 6];
            2:       return 1'($urandom_range(0, 1));
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    // Runs one start request and checks it against the ordered word list it must produce.
    task automatic run_block(input int base, input int len, input int mode, input bit timing,
                             output int words, output int errs);
        logic [DATA_W-1:0] exp_q [$];
        logic [DATA_W-1:0] exp_word;
        logic [DATA_W-1:0] held;
        bit                exp_err, stall, finished;
        int                issues, dones, budget;
        exp_err = (base + len > DEPTH);
        if (!exp_err) for (int i = 0; i < len; i++) exp_q.push_back(mem_model[base + i]);
        words = 0; errs = 0; issues = 0; dones = 0;
        stall = 1'b0; finished = 1'b0; held = '0;
        budget = 4 * len + 20;
        for (int k = 0; k < budget && !finished; k++) begin
            @(posedge clk); #1;
            start     = (k == 0);
            base_addr = ADDR_W'(base);
            length    = LEN_W'(len);
            ready     = ready_fn(mode, k);
            @(negedge clk);
            check("busy", busy, (!exp_err && k >= 1));
            if (stall) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_data", bus.out_data, held);
            end
            if (bus.mem_chipselect) begin
                check("rd_addr", bus.mem_address, base + issues);
                if (timing) check("rd_cycle", k, issues + 1);
                issues++;
            end
            if (bus.out_valid) check("out_last", bus.out_last, (exp_q.size() == 1));
            if (bus.out_valid && bus.out_ready) begin
                exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
                check("out_data", bus.out_data, exp_word);
                if (timing) check("xfer_cycle", k, words + 2);
                words++;
            end
            check("issue_ahead", (issues - words <= 2), 1);
            if (done) begin
                dones++;
                check("done_tail", exp_q.size(), 0);
                if (timing) check("done_cycle", k, len + 1);
                finished = 1'b1;
            end
            if (error) begin
                errs++;
                check("err_cycle", k, 1);
                finished = 1'b1;
            end
            stall = bus.out_valid && !bus.out_ready;
            held  = bus.out_data;
        end
        check("block_end", finished, 1);
        @(posedge clk); #1;
        start = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        check("post_busy", busy, 0);
        check("post_valid", bus.out_valid, 0);
        check("post_cs", bus.mem_chipselect, 0);
        check("post_done", done, 0);
        check("issues", issues, exp_err ? 0 : len);
        check("done_seen", dones, exp_err ? 0 : 1);
    endtask

    typedef struct {
        int base;
        int len;
        int mode;
        bit timing;
        int exp_words;
        int exp_err;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int w, e, b, l;
        for (int i = 0; i < DEPTH; i++) mem_model[i] = DATA_W'(i * 3);

        tbl[0] = '{10,  4,   0, 1'b1, 4,   0};
        tbl[1] = '{10,  4,   1, 1'b0, 4,   0};
        tbl[2] = '{340, 3,   0, 1'b1, 0,   1};
        tbl[3] = '{339, 3,   0, 1'b1, 3,   0};
        tbl[4] = '{5,   0,   0, 1'b1, 0,   0};
        tbl[5] = '{0,   342, 0, 1'b1, 342, 0};
        tbl[6] = '{341, 1,   1, 1'b0, 1,   0};
        tbl[7] = '{0,   343, 0, 1'b1, 0,   1};
        tbl[8] = '{511, 1,   0, 1'b1, 0,   1};
        tbl[9] = '{300, 42,  2, 1'b0, 42,  0};

        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        ready     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_last", bus.out_last, 0);
        check("rst_cs", bus.mem_chipselect, 0);
        check("rst_addr", bus.mem_address, 0);
        check("const_clken", bus.mem_clken, 1);
        check("const_write", bus.mem_write, 0);
        check("const_be", bus.mem_byteenable, 15);
        check("const_wdata", bus.mem_writedata, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int t = 0; t < 10; t++) begin
            run_block(tbl[t].base, tbl[t].len, tbl[t].mode, tbl[t].timing, w, e);
            check("tbl_words", w, tbl[t].exp_words);
            check("tbl_err", e, tbl[t].exp_err);
        end

        for (int r = 0; r < 24; r++) begin
            b = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(0, 24);
            if (r % 6 == 5) b = $urandom_range(DEPTH - 12, 511);
            if (l == 0 && b == DEPTH) b = DEPTH + 1;
            run_block(b, l, 2 + (r % 2), 1'b0, w, e);
            check("rnd_words", w, (b + l > DEPTH) ? 0 : l);
            check("rnd_err", e, (b + l > DEPTH) ? 1 : 0);
        end

        // Block of 8 from 20: a second start must be ignored, then reset after 3 words.
        @(posedge clk); #1;
        start = 1'b1; base_addr = 9'd20; length = 10'd8; ready = 1'b1;
        w = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            start = (k == 2); base_addr = 9'd100; length = 10'd2;
            @(negedge clk);
            check("mid_busy", busy, 1);
            if (bus.mem_chipselect) check("mid_addr", bus.mem_address, 20 + k - 1);
            if (bus.out_valid && ready) begin
                check("mid_data", bus.out_data, mem_model[20 + w]);
                w++;
            end
        end
        check("mid_words", w, 3);
        @(posedge clk); #1;
        start   = 1'b0;
        reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", bus.out_valid, 0);
        check("arst_last", bus.out_last, 0);
        check("arst_cs", bus.mem_chipselect, 0);
        check("arst_addr", bus.mem_address, 0);
        check("arst_done", done, 0);
        repeat (2) begin
            @(negedge clk);
            check("arst_hold_done", done, 0);
            check("arst_hold_valid", bus.out_valid, 0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_block(0, 2, 0, 1'b1, w, e);
        check("post_rst_words", w, 2);
        check("post_rst_err", e, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_block_reader.md
Name: data_mem_block_reader

Overview:
- Avalon-MM read master sitting directly upstream of the 342-word x 32-bit single-port on-chip data memory (s1 port). It drives that memory's address/chipselect/clken and consumes its readdata.
- On a start pulse, streams a contiguous block of words out on a valid/ready stream interface, with backpressure and a 2-entry buffer that absorbs the memory's 1-cycle read latency.
- Used to feed memory contents to a stream consumer (e.g. FIFO or peripheral) without CPU polling.

Parameters:
- DATA_W, 32, memory/stream word width
- ADDR_W, 9, memory word-address width
- DEPTH, 342, number of valid memory words; highest legal address is DEPTH-1
- LEN_W, 10, width of the length field (must hold DEPTH)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first word address, sampled with start
- length  in  LEN_W  word count, sampled with start
- busy  out  1  high from accepted start until the done/error cycle, inclusive
- done  out  1  one-cycle pulse when the last word is accepted by the sink
- error  out  1  one-cycle pulse when a start is rejected (range fault)
- mem_address  out  ADDR_W  to memory address
- mem_chipselect  out  1  high only on read-issue cycles
- mem_clken  out  1  constant 1
- mem_write  out  1  constant 0
- mem_byteenable  out  4  constant 4'hF
- mem_writedata  out  DATA_W  constant 0
- mem_readdata  in  DATA_W  memory data, valid 1 cycle after an issue cycle
- out_data  out  DATA_W  stream data
- out_valid  out  1  stream valid
- out_last  out  1  marks the final word of the block; qualified by out_valid
- out_ready  in  1  sink ready; transfer = out_valid & out_ready

Behaviour:
- Reset (reset_n=0, asynchronous): state IDLE; busy, done, error, out_valid, out_last, mem_chipselect = 0; mem_address = 0; buffer emptied; in-flight read discarded. Reset mid-block aborts silently, with no done pulse.
- Range check: on start in IDLE, if base_addr + length > DEPTH (computed at LEN_W+1 bits), pulse error for 1 cycle, stay IDLE, issue nothing.
- length == 0 with a legal base: pulse done 1 cycle after start, busy high that cycle only, issue nothing.
- start while busy is ignored. Inputs are sampled only on the accepted start cycle.
- States:
  - IDLE: wait for start; on a legal nonzero start -> RUN, with addr=base_addr and issue_rem=recv_rem=length.
  - RUN: issue reads while issue_rem>0; -> DRAIN when issue_rem reaches 0.
  - DRAIN: wait until recv_rem=0 -> IDLE, asserting done in the cycle the last transfer occurs.
- Issue rule: occupancy = buffer count + in-flight (0/1). Issue in a cycle when issue_rem>0 and (occupancy<2, or occupancy==2 and a stream transfer occurs this cycle). On issue: mem_chipselect=1, mem_address=addr; then addr+1, issue_rem-1.
- Read latency: data for an issue in cycle N is captured from mem_readdata at the end of cycle N+1. The buffer never overflows and never drops data.
- Latency: start at cycle 0 -> first issue cycle 1 -> out_valid in cycle 2 (buffer registered). With out_ready held high, the stream runs at 1 word/cycle. A block of L words completes with done in cycle L+1.
- Buffer: 2-entry FIFO; out_data/out_valid are driven from its head. out_valid must not drop until a transfer occurs. out_last=1 when the head word is the final word of the block (recv_rem==1).
- Simultaneous push and pop on a full buffer is allowed, and the count is unchanged.
- Address never exceeds DEPTH-1; with the range check there is no wrap-around.

Decomposition:
- Shared package: state enum (IDLE/RUN/DRAIN), DEPTH/ADDR_W/LEN_W constants shared with the memory wrapper.
- One sub-module: data_mem_rd_skid_fifo (2-entry valid/ready buffer with count output).

Test Plan:
- Preload mem[i]=i*3. start, base=10, len=4, out_ready=1 -> mem_address 10,11,12,13 in cycles 1-4; out_data 30,33,36,39 in cycles 2-5; out_last with 39; done in cycle 5.
- Same block, out_ready toggled 1,0,0,1,0,1,...: no word lost or duplicated; out_valid/out_data stable while stalled; at most 2 issues ahead of the sink.
- base=340, len=3 -> error pulse, busy never set, mem_chipselect stays 0. base=339, len=3 -> reads 339,340,341, then done.
- len=0, base=5 -> done 1 cycle after start, no chipselect, no out_valid.
- Block len=8: second start mid-block is ignored. Assert reset_n=0 after 3 transfers -> outputs zero immediately; after release a new start, base=0, len=2, runs cleanly.
- base=0, len=342 with out_ready=1 -> 342 words in order, out_last only on word 341, done once.
